hsid_mse: RTL and testbench

HSID_MSE -- requirements
Module: hsid_mse

---
 rtl/hsid_pkg.sv | 20 ++
 rtl/hsid_sq_df.sv | 36 +++
 rtl/hsid_mse.sv | 182 ++++++++++++++++++
 tb/tb_hsid_mse.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared widths and pipeline control type for the hyperspectral MSE datapath.
package hsid_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_DATA_WIDTH        = HSID_WORD_WIDTH / 2;
  localparam int HSID_HSP_BANDS_WIDTH   = 12;
  localparam int HSID_HSP_LIBRARY_WIDTH = 10;
  localparam int HSID_MSE_WIDTH         = 32;

  typedef struct packed {
    logic valid;
    logic start;
    logic last;
  } hsid_ctl_t;

  function automatic int hsid_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hsid_sq_df.sv
// One lane: registered |a-b| followed by a registered full-precision square.
module hsid_sq_df
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   sq
);

  localparam int SQ_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] diff_r;

  // Absolute difference stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= '0;
    end else begin
      diff_r <= (a >= b) ? (a - b) : (b - a);
    end
  end

  // Square stage, widened before the multiply so nothing is truncated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq <= '0;
    end else begin
      sq <= SQ_W'(diff_r) * SQ_W'(diff_r);
    end
  end

endmodule

// File: rtl/hsid_mse.sv
// Five-stage sum-of-squared-differences engine, two bands per word.
// Define HSID_MSE_SAT_EN to saturate the accumulator instead of wrapping.
module hsid_mse
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter int MSE_WIDTH         = HSID_MSE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         band_pack_valid,
  input  logic                         band_pack_start,
  input  logic                         band_pack_last,
  input  logic [WORD_WIDTH-1:0]        vctr1,
  input  logic [WORD_WIDTH-1:0]        vctr2,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_idx,
  output logic                         mse_valid,
  output logic [MSE_WIDTH-1:0]         mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_ref,
  output logic                         mse_overflow
);

  localparam int DW    = WORD_WIDTH / 2;
  localparam int SQ_W  = 2 * DW;
  localparam int SUM_W = SQ_W + 1;
  localparam int EXT_W = hsid_max(MSE_WIDTH, SUM_W) + 1;

  hsid_ctl_t s1_ctl_r, s2_ctl_r, s3_ctl_r, s4_ctl_r;
  logic [HSP_LIBRARY_WIDTH-1:0] s1_ref_r, s2_ref_r, s3_ref_r, s4_ref_r;
  logic [WORD_WIDTH-1:0] s1_v1_r, s1_v2_r;
  logic [SQ_W-1:0]       sq_s [2];
  logic [SUM_W-1:0]      s4_sum_r;

  logic [MSE_WIDTH-1:0]  acc_r;
  logic                  ovf_r;
  logic                  in_ref_r;
  logic                  res_valid_r;
  logic [MSE_WIDTH-1:0]  res_val_r;
  logic [HSP_LIBRARY_WIDTH-1:0] res_ref_r;
  logic                  res_ovf_r;

  logic                  mask_hi_s;
  logic [EXT_W-1:0]      total_s;
  logic [MSE_WIDTH-1:0]  acc_nxt_s;
  logic                  pack_ovf_s;
  logic                  ovf_nxt_s;
  logic                  take_s;
  logic                  emit_s;
  logic                  unused_bands_s;

  // Only the parity of the band count matters to the datapath.
  assign unused_bands_s = &{1'b0, hsp_bands[HSP_BANDS_WIDTH-1:1]};
  assign mask_hi_s      = band_pack_valid & band_pack_last & hsp_bands[0];

  // S1 input register; an odd band count zeroes both upper halves of the last pack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl_r <= '0;
      s1_ref_r <= '0;
      s1_v1_r  <= '0;
      s1_v2_r  <= '0;
    end else if (clear) begin
      s1_ctl_r <= '0;
    end else begin
      s1_ctl_r.valid <= band_pack_valid;
      s1_ctl_r.start <= band_pack_valid & band_pack_start;
      s1_ctl_r.last  <= band_pack_valid & band_pack_last;
      s1_ref_r       <= hsp_ref_idx;
      s1_v1_r        <= mask_hi_s ? {{DW{1'b0}}, vctr1[DW-1:0]} : vctr1;
      s1_v2_r        <= mask_hi_s ? {{DW{1'b0}}, vctr2[DW-1:0]} : vctr2;
    end
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    hsid_sq_df #(.DATA_WIDTH(DW)) u_sq_df (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (s1_v1_r[l*DW +: DW]),
      .b     (s1_v2_r[l*DW +: DW]),
      .sq    (sq_s[l])
    );
  end

  // Control and reference index ride alongside S2..S4; S4 also forms the lane sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ctl_r <= '0;
      s3_ctl_r <= '0;
      s4_ctl_r <= '0;
      s2_ref_r <= '0;
      s3_ref_r <= '0;
      s4_ref_r <= '0;
      s4_sum_r <= '0;
    end else if (clear) begin
      s2_ctl_r <= '0;
      s3_ctl_r <= '0;
      s4_ctl_r <= '0;
    end else begin
      s2_ctl_r <= s1_ctl_r;
      s3_ctl_r <= s2_ctl_r;
      s4_ctl_r <= s3_ctl_r;
      s2_ref_r <= s1_ref_r;
      s3_ref_r <= s2_ref_r;
      s4_ref_r <= s3_ref_r;
      s4_sum_r <= SUM_W'(sq_s[0]) + SUM_W'(sq_s[1]);
    end
  end

  // S5 accumulate; packs arriving outside an open reference are dropped.
  always_comb begin
    total_s    = (s4_ctl_r.start ? {EXT_W{1'b0}} : EXT_W'(acc_r)) + EXT_W'(s4_sum_r);
`ifdef HSID_MSE_SAT_EN
    pack_ovf_s = |total_s[EXT_W-1:MSE_WIDTH];
    acc_nxt_s  = pack_ovf_s ? {MSE_WIDTH{1'b1}} : total_s[MSE_WIDTH-1:0];
`else
    pack_ovf_s = 1'b0;
    acc_nxt_s  = total_s[MSE_WIDTH-1:0];
`endif
    ovf_nxt_s  = (s4_ctl_r.start ? 1'b0 : ovf_r) | pack_ovf_s;
    take_s     = s4_ctl_r.valid & (s4_ctl_r.start | in_ref_r);
    emit_s     = take_s & s4_ctl_r.last;
  end

`ifndef HSID_MSE_SAT_EN
  logic unused_hi_s;
  assign unused_hi_s = |total_s[EXT_W-1:MSE_WIDTH];
`endif

  // S5 state: accumulator, open-reference flag and staged result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      in_ref_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_val_r   <= '0;
      res_ref_r   <= '0;
      res_ovf_r   <= 1'b0;
    end else if (clear) begin
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      in_ref_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= emit_s;
      if (take_s) begin
        acc_r    <= emit_s ? {MSE_WIDTH{1'b0}} : acc_nxt_s;
        ovf_r    <= emit_s ? 1'b0 : ovf_nxt_s;
        in_ref_r <= ~emit_s;
      end
      if (emit_s) begin
        res_val_r <= acc_nxt_s;
        res_ref_r <= s4_ref_r;
        res_ovf_r <= ovf_nxt_s;
      end
    end
  end

  // Output register; value, index and overflow hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mse_valid    <= 1'b0;
      mse_value    <= '0;
      mse_ref      <= '0;
      mse_overflow <= 1'b0;
    end else if (clear) begin
      mse_valid    <= 1'b0;
    end else begin
      mse_valid <= res_valid_r;
      if (res_valid_r) begin
        mse_value    <= res_val_r;
        mse_ref      <= res_ref_r;
        mse_overflow <= res_ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_hsid_mse.sv
// Directed and randomized bench for hsid_mse against a band-list reference model.
module tb_hsid_mse;
  import hsid_pkg::*;

  localparam int WW = HSID_WORD_WIDTH;
  localparam int DW = HSID_DATA_WIDTH;
  localparam int BW = HSID_HSP_BANDS_WIDTH;
  localparam int LW = HSID_HSP_LIBRARY_WIDTH;
  localparam int MW = HSID_MSE_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          band_pack_valid = 1'b0;
  logic          band_pack_start = 1'b0;
  logic          band_pack_last = 1'b0;
  logic [WW-1:0] vctr1 = '0;
  logic [WW-1:0] vctr2 = '0;
  logic [BW-1:0] hsp_bands = '0;
  logic [LW-1:0] hsp_ref_idx = '0;
  logic          mse_valid;
  logic [MW-1:0] mse_value;
  logic [LW-1:0] mse_ref;
  logic          mse_overflow;

  hsid_mse dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .band_pack_valid (band_pack_valid),
    .band_pack_start (band_pack_start),
    .band_pack_last  (band_pack_last),
    .vctr1           (vctr1),
    .vctr2           (vctr2),
    .hsp_bands       (hsp_bands),
    .hsp_ref_idx     (hsp_ref_idx),
    .mse_valid       (mse_valid),
    .mse_value       (mse_value),
    .mse_ref         (mse_ref),
    .mse_overflow    (mse_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [MW-1:0] val;
    logic [LW-1:0] rf;
    logic        ovf;
  } exp_t;

  exp_t          exp_q[$];
  longint        diffs[$];
  bit            active = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [MW-1:0] held_val = '0;
  logic [LW-1:0] held_ref = '0;

  // One clock edge, then check whatever the DUT presents against the model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (mse_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL spurious_valid got value=%0h want no result", mse_value);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (cyc === e.due) else begin
          errors++; $error("FAIL latency got cycle %0d want %0d", cyc, e.due);
        end
        checks++;
        assert (mse_value === e.val) else begin
          errors++; $error("FAIL value got %0h want %0h", mse_value, e.val);
        end
        checks++;
        assert (mse_ref === e.rf) else begin
          errors++; $error("FAIL ref got %0d want %0d", mse_ref, e.rf);
        end
        checks++;
        assert (mse_overflow === e.ovf) else begin
          errors++; $error("FAIL overflow got %0b want %0b", mse_overflow, e.ovf);
        end
        held_val = e.val;
        held_ref = e.rf;
      end
    end else begin
      checks++;
      assert (exp_q.size() == 0 || exp_q[0].due != cyc) else begin
        errors++; $error("FAIL missing_valid got 0 want 1 at cycle %0d", cyc);
      end
      checks++;
      assert (mse_value === held_val && mse_ref === held_ref) else begin
        errors++; $error("FAIL hold got %0h/%0d want %0h/%0d", mse_value, mse_ref, held_val, held_ref);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drive one valid pack; the model keeps the band differences of the open reference.
  task automatic send(input int lo1, input int hi1, input int lo2, input int hi2,
                      input bit st, input bit ls, input int idx);
    exp_t   e;
    longint sum;
    longint maxv;
    int     nb;
    band_pack_valid = 1'b1;
    band_pack_start = st;
    band_pack_last  = ls;
    vctr1 = {DW'(hi1), DW'(lo1)};
    vctr2 = {DW'(hi2), DW'(lo2)};
    hsp_ref_idx = LW'(idx);
    if (st) begin
      diffs.delete();
      active = 1'b1;
    end
    if (active) begin
      diffs.push_back((lo1 > lo2) ? lo1 - lo2 : lo2 - lo1);
      diffs.push_back((hi1 > hi2) ? hi1 - hi2 : hi2 - hi1);
      if (ls) begin
        nb = int'(hsp_bands);
        sum = 0;
        for (int i = 0; i < nb && i < diffs.size(); i++) sum += diffs[i] * diffs[i];
        maxv = (64'sd1 <<< MW) - 1;
        e.due = cyc + 6;
        e.rf  = LW'(idx);
`ifdef HSID_MSE_SAT_EN
        e.ovf = (sum > maxv);
        e.val = e.ovf ? {MW{1'b1}} : MW'(sum);
`else
        e.ovf = 1'b0;
        e.val = MW'(sum & maxv);
`endif
        exp_q.push_back(e);
        active = 1'b0;
      end
    end
    tick();
    band_pack_valid = 1'b0;
    band_pack_start = 1'($urandom);
    band_pack_last  = 1'($urandom);
    vctr1 = WW'($urandom);
    vctr2 = WW'($urandom);
  endtask

  initial begin
    int nv;
    int bands;
    int npk;
    int idx;
    bit big;
    int a[4];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (mse_valid === 1'b0 && mse_value === '0 && mse_ref === '0 && mse_overflow === 1'b0) else begin
      errors++; $error("FAIL reset_state got %0b/%0h/%0d/%0b want all 0", mse_valid, mse_value, mse_ref, mse_overflow);
    end
    rst_n = 1'b1;

    // Four bands over two packs: 9+16+1+1
    hsp_bands = BW'(4);
    send(10, 20, 7, 24, 1'b1, 1'b0, 3);
    send(0, 0, 1, 1, 1'b0, 1'b1, 3);
    idle(7);
    checks++;
    assert (mse_value === MW'(27) && mse_ref === LW'(3)) else begin
      errors++; $error("FAIL dir_27 got %0d/%0d want 27/3", mse_value, mse_ref);
    end

    // Odd band count masks the upper lane of the last pack
    hsp_bands = BW'(3);
    send(5, 0, 2, 0, 1'b1, 1'b0, 7);
    send(5, 100, 2, 0, 1'b0, 1'b1, 7);
    idle(7);
    checks++;
    assert (mse_value === MW'(18) && mse_ref === LW'(7)) else begin
      errors++; $error("FAIL dir_18 got %0d/%0d want 18/7", mse_value, mse_ref);
    end

    // Back-to-back single-pack references
    hsp_bands = BW'(2);
    send(2, 0, 0, 0, 1'b1, 1'b1, 1);
    send(3, 0, 0, 0, 1'b1, 1'b1, 2);
    idle(7);

    // Clear one cycle after last drops the in-flight result
    hsp_bands = BW'(2);
    send(9, 9, 1, 1, 1'b1, 1'b1, 11);
    clear = 1'b1;
    exp_q.delete();
    active = 1'b0;
    tick();
    clear = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nv += int'(mse_valid);
    end
    checks++;
    assert (nv == 0) else begin
      errors++; $error("FAIL clear_flush got %0d strobes want 0", nv);
    end
    hsp_bands = BW'(4);
    send(4, 1, 1, 3, 1'b1, 1'b0, 12);
    send(2, 7, 2, 2, 1'b0, 1'b1, 12);
    idle(7);

    // Large operands: saturates with the macro, wraps without it
    hsp_bands = BW'(4);
    send(65535, 65535, 0, 0, 1'b1, 1'b0, 5);
    send(65535, 65535, 0, 0, 1'b0, 1'b1, 5);
    idle(7);

    // Reset pulse mid-reference, then a continuation without start
    hsp_bands = BW'(4);
    send(30, 40, 1, 2, 1'b1, 1'b0, 9);
    rst_n = 1'b0;
    #2;
    checks++;
    assert (mse_valid === 1'b0 && mse_value === '0 && mse_ref === '0 && mse_overflow === 1'b0) else begin
      errors++; $error("FAIL async_reset got %0b/%0h/%0d/%0b want all 0", mse_valid, mse_value, mse_ref, mse_overflow);
    end
    held_val = '0;
    held_ref = '0;
    exp_q.delete();
    active = 1'b0;
    rst_n = 1'b1;
    send(3, 3, 0, 0, 1'b0, 1'b1, 9);
    idle(8);

    // Randomized references with bubbles and random gaps
    for (int r = 0; r < 24; r++) begin
      bands = $urandom_range(1, 8);
      hsp_bands = BW'(bands);
      npk = (bands + 1) / 2;
      idx = $urandom_range(0, (1 << LW) - 1);
      big = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < npk; p++) begin
        for (int k = 0; k < 4; k++) a[k] = big ? $urandom_range(0, 65535) : $urandom_range(0, 255);
        send(a[0], a[1], a[2], a[3], p == 0, p == npk - 1, idx);
        if ($urandom_range(0, 3) == 0) tick();
      end
      idle($urandom_range(0, 2));
    end
    idle(10);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL leftover got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
